// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial CLA add/subtract sequencer.
package cla_seq_adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Nibble index width; never narrower than one bit so WIDTH=4 still has an index.
  function automatic int unsigned idx_w(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_slice.sv
// Combinational 4-bit carry-lookahead slice: P/G generation, lookahead carries, nibble sum.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic [4:1] c
);

  logic [3:0] p;
  logic [3:0] g;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    s    = p ^ {c[3:1], c0};
  end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit add/subtract sequencer reusing one 4-bit CLA slice, one nibble per cycle, LSB first.
module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = idx_w(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [3:0]         sl_s;
  logic [4:1]         sl_c;
  logic               last_pass;

  assign last_pass = (idx_q == LAST_IDX);

  cla4_slice u_slice (
    .a  (a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .b  (b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .c0 (carry_q),
    .s  (sl_s),
    .c  (sl_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_pass) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtract is folded in at acceptance: B is stored inverted and the carry seeded with 1.
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub | cin;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = sl_s;
        carry_d = sl_c[4];
        idx_d   = idx_q + IDX_W'(1);
        if (last_pass) begin
          idx_d  = '0;
          cout_d = sl_c[4];
          ovf_d  = sl_c[3] ^ sl_c[4];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench: per-cycle comparison against a transaction-level arithmetic model plus directed vectors.
module tb_cla_seq_adder_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic: full-width add of A and (possibly inverted) B with carry-in.
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                               input logic rsub, input logic rcin);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         c0;
    logic         v;
    bb   = rsub ? ~rb : rb;
    c0   = rsub ? 1'b1 : rcin;
    full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, c0};
    v    = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
    return {v, full};
  endfunction

  // Transaction-level model: idle / busy with result due N+1 cycles after the handshake cycle.
  logic         m_busy = 1'b0;
  int           m_start = 0;
  int           ncyc = 0;
  logic [W+1:0] m_exp = '0;
  logic [W+1:0] m_last = '0;

  always @(negedge clk) begin
    logic exp_ov;
    logic [W+1:0] ref_now;
    ncyc++;
    exp_ov = m_busy && ((ncyc - m_start) >= N + 1);
    check("in_ready",  32'(in_ready),  32'(!m_busy));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (!m_busy || exp_ov) begin
      ref_now = m_busy ? m_exp : m_last;
      check("sum",  32'(sum),  32'(ref_now[W-1:0]));
      check("cout", 32'(cout), 32'(ref_now[W]));
      check("ovf",  32'(ovf),  32'(ref_now[W+1]));
    end
    if (rst) begin
      m_busy = 1'b0;
      m_last = '0;
    end else if (!m_busy && in_valid) begin
      m_exp   = ref_result(a, b, sub, cin);
      m_busy  = 1'b1;
      m_start = ncyc;
    end else if (exp_ov && out_ready) begin
      m_busy = 1'b0;
      m_last = m_exp;
    end
  end

  task automatic wait_accept(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'(0), 32'(1));
  endtask

  // Drives one operation, checks latency and literal results, optionally holds out_ready low.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input logic tc, input int hold, input logic [W-1:0] es,
                       input logic ec, input logic eo);
    bit ok;
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
    out_ready = (hold == 0);
    wait_accept(ok);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", 32'(lat), 32'(N + 1));
    check("d_sum",  32'(sum),  32'(es));
    check("d_cout", 32'(cout), 32'(ec));
    check("d_ovf",  32'(ovf),  32'(eo));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555;
      end
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_sum",   32'(sum),       32'(es));
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int prev;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_sum",      32'(sum),      32'(0));

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b1, 0, 16'h2202, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1);
    do_op(16'h4321, 16'h1111, 1'b0, 1'b0, 6, 16'h5432, 1'b0, 1'b0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 16'h1000, 1'b0, 1'b0);

    // Reset on the second RUN cycle.
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
    wait_accept(ok);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mr_in_ready",  32'(in_ready),  32'(1));
    check("mr_out_valid", 32'(out_valid), 32'(0));
    check("mr_sum",       32'(sum),       32'(0));
    check("mr_cout",      32'(cout),      32'(0));
    check("mr_ovf",       32'(ovf),       32'(0));
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back random operations with in_valid held and out_ready tied high.
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      wait_accept(ok);
      if (!ok) break;
      if (k > 0) check("spacing", 32'(cyc - prev), 32'(N + 2));
      prev = cyc;
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    end
    in_valid = 1'b0;
    repeat (N + 4) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
